// File: rtl/map_ram_arbiter_pkg.sv
// Shared definitions for the map RAM arbiter.
//
// Holds the CPU FSM state encoding, the fixed video read latency, the map geometry, the default
// bus widths, the tile codes shared with the colorizer and the {valid, owner} read tag that
// travels alongside each RAM read.
package map_arb_pkg;

  // Default bus widths: address is {row[6:0], col[7:0]}, data is a 2-bit tile code.
  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W_DEF = 2;

  // Video request to vid_valid, in cycles.
  localparam int unsigned VID_LAT = 3;

  // Visible map size. Addresses outside it are passed through untouched.
  localparam int unsigned MAP_COLS = 160;
  localparam int unsigned MAP_ROWS = 120;

  // CPU access FSM encoding.
  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StCpuCmd    = 2'd1;
  localparam logic [1:0] StCpuRdWait = 2'd2;
  localparam logic [1:0] StCpuAck    = 2'd3;

  // Tile codes as understood by the colorizer.
  typedef enum logic [1:0] {
    TileFloor = 2'b00,
    TileWall  = 2'b01,
    TileIcon  = 2'b10,
    TileGoal  = 2'b11
  } tile_e;

  // Which requester a RAM read belongs to.
  typedef enum logic {
    OwnVid = 1'b0,
    OwnCpu = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  // Build a map address from a pixel-derived row/column pair.
  function automatic logic [ADDR_W_DEF-1:0] map_addr(input logic [6:0] row,
                                                     input logic [7:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/map_ram_arbiter_if.sv
// Bus bundle between the two requesters, the RAM and the map RAM arbiter.
//
// Signals:
//   vid_req/vid_addr -> vid_rdata/vid_valid          video fetch path
//   cpu_req/we/addr/wdata -> cpu_rdata/cpu_ack        PicoBlaze port-register path
//   ram_en/we/addr/wdata, ram_rdata                   single-port map RAM
//   cpu_starved, conflict_cnt                          only with MAP_ARB_STATS_EN
// Modports:
//   slave  - the arbiter
//   master - the requesters and RAM around it
interface map_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 2
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

`ifdef MAP_ARB_STATS_EN
  logic              cpu_starved;
  logic [15:0]       conflict_cnt;
`endif

  modport slave (
    input  vid_req,
    input  vid_addr,
    output vid_rdata,
    output vid_valid,
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_rdata,
    output cpu_ack,
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
`ifdef MAP_ARB_STATS_EN
    ,
    output cpu_starved,
    output conflict_cnt
`endif
  );

  modport master (
    output vid_req,
    output vid_addr,
    input  vid_rdata,
    input  vid_valid,
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_rdata,
    input  cpu_ack,
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
`ifdef MAP_ARB_STATS_EN
    ,
    input  cpu_starved,
    input  conflict_cnt
`endif
  );

endinterface

// File: rtl/map_ram_arbiter_tag_pipe.sv
// Read tag pipe for the map RAM arbiter.
//
// A short shift register that follows each issued RAM read with a {valid, owner} tag, so the
// tag reaches its last stage in the cycle ram_rdata is valid for that read.
// Ports:
//   clk_i     system clock
//   rst_ni    synchronous reset, active-low
//   tag_i     tag for the RAM command being registered this edge
//   vid_cap_o ram_rdata belongs to a video read (drives vid_valid next edge)
//   cpu_cap_o ram_rdata belongs to a CPU read (capture strobe for cpu_rdata)
module map_arb_tag_pipe
  import map_arb_pkg::*;
#(
  parameter int unsigned Depth = VID_LAT - 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output logic vid_cap_o,
  output logic cpu_cap_o
);

  tag_t tag_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < int'(Depth); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign vid_cap_o = tag_q[Depth-1].valid && (tag_q[Depth-1].owner == OwnVid);
  assign cpu_cap_o = tag_q[Depth-1].valid && (tag_q[Depth-1].owner == OwnCpu);

endmodule

// File: rtl/map_ram_arbiter.sv
// Map RAM arbiter: shares one single-port map RAM between the video fetch path and the CPU.
//
// Video has fixed priority and a fixed 3-cycle read latency, fully pipelined. CPU accesses use a
// level req / pulse ack handshake and are slotted into cycles with no video request.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-low
//   bus  map_ram_arbiter_if.slave: video, CPU and RAM signals
// Optional: define MAP_ARB_STATS_EN to add cpu_starved / conflict_cnt (and STARVE_LIMIT).
module map_ram_arbiter
  import map_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef MAP_ARB_STATS_EN
  ,
  parameter int unsigned STARVE_LIMIT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  map_ram_arbiter_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic vid_grant;
  logic cpu_grant;
  logic vid_cap;
  logic cpu_cap;
  tag_t tag_in;

  // Video always wins; the CPU only gets a slot from IDLE, so at most one CPU access is in flight.
  assign vid_grant = bus.vid_req;
  assign cpu_grant = ~bus.vid_req & bus.cpu_req & (state_q == StIdle);

  // RAM command for the next cycle. Address/wdata hold when idle to avoid needless toggling.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (vid_grant) begin
      ram_en_d   = 1'b1;
      ram_addr_d = bus.vid_addr;
    end else if (cpu_grant) begin
      ram_en_d    = 1'b1;
      ram_we_d    = bus.cpu_we;
      ram_addr_d  = bus.cpu_addr;
      ram_wdata_d = bus.cpu_wdata;
    end
  end

  // Only reads need a tag; CPU writes complete through the FSM alone.
  always_comb begin
    tag_in.valid = vid_grant | (cpu_grant & ~bus.cpu_we);
    tag_in.owner = vid_grant ? OwnVid : OwnCpu;
  end

  map_arb_tag_pipe #(
    .Depth(VID_LAT - 1)
  ) u_tag_pipe (
    .clk_i    (clk),
    .rst_ni   (rst),
    .tag_i    (tag_in),
    .vid_cap_o(vid_cap),
    .cpu_cap_o(cpu_cap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (cpu_grant) state_d = StCpuCmd;
      // ram_we_q is the CPU's own command while in CPU_CMD.
      StCpuCmd:    state_d = ram_we_q ? StCpuAck : StCpuRdWait;
      StCpuRdWait: state_d = StCpuAck;
      StCpuAck:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    vid_rdata_d = vid_cap ? bus.ram_rdata : vid_rdata_q;
    cpu_rdata_d = cpu_cap ? bus.ram_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      vid_valid_q <= vid_cap;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = (state_q == StCpuAck);

`ifdef MAP_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] cpu_wait_q, cpu_wait_d;
  logic        collide;

  // A collision is a cycle where a CPU request is waiting in IDLE and video takes the slot.
  assign collide = bus.vid_req & bus.cpu_req & (state_q == StIdle);

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (collide && (conflict_cnt_q != 16'hffff)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
    cpu_wait_d = cpu_wait_q;
    if (!bus.cpu_req || cpu_grant) begin
      cpu_wait_d = '0;
    end else if (collide && (cpu_wait_q != 16'hffff)) begin
      cpu_wait_d = cpu_wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt_q <= '0;
      cpu_wait_q     <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      cpu_wait_q     <= cpu_wait_d;
    end
  end

  assign bus.cpu_starved  = (32'(cpu_wait_q) >= STARVE_LIMIT);
  assign bus.conflict_cnt = conflict_cnt_q;
`endif

endmodule
